// File: rtl/wb_pkg.sv
// Shared widths and queue entry type for the register file write-back path.
package wb_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// Producer handshakes, register file write port and forwarding lookup of regfile_writeback.
interface regfile_writeback_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_dest;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              regwrite;
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] fwd_addr1;
  logic [ADDR_W-1:0] fwd_addr2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;

  modport master (
    output alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data, fwd_addr1, fwd_addr2,
    input  alu_ready, ld_ready, regwrite, dest, write_data,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data, fwd_addr1, fwd_addr2,
    output alu_ready, ld_ready, regwrite, dest, write_data,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
endinterface

// File: rtl/wb_fifo.sv
// In-order write-back queue: two ordered pushes (i_push0 older), one pop, exported contents.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push0,
  input  wb_entry_t        i_entry0,
  input  logic             i_push1,
  input  wb_entry_t        i_entry1,
  input  logic             i_pop,
  output logic [CNT_W-1:0] o_count,
  output logic [PTR_W-1:0] o_head_ptr,
  output wb_entry_t        o_head,
  output wb_entry_t        o_entries [DEPTH],
  output logic [DEPTH-1:0] o_valid
);
  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       w_npush;
  logic [PTR_W-1:0] w_wr_ptr1;

  assign w_npush   = {1'b0, i_push0} + {1'b0, i_push1};
  // The younger entry lands one slot past the older one only when both push.
  assign w_wr_ptr1 = i_push0 ? r_tail + PTR_W'(1) : r_tail;

  always_ff @(posedge clk) begin
    if (i_push0) r_mem[r_tail]    <= i_entry0;
    if (i_push1) r_mem[w_wr_ptr1] <= i_entry1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + PTR_W'(w_npush);
      if (i_pop) r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_npush) - CNT_W'(i_pop);
    end
  end

  always_comb begin
    logic [PTR_W-1:0] w_off;
    w_off   = '0;
    o_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_off      = PTR_W'(i) - r_head;
      o_valid[i] = ({1'b0, w_off} < r_count);
    end
  end

  assign o_count    = r_count;
  assign o_head_ptr = r_head;
  assign o_head     = r_mem[r_head];
  assign o_entries  = r_mem;
endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and load results into one register file write per cycle via wb_fifo.
// REGFILE_WB_FORWARD_EN builds the forwarding search; otherwise fwd_hit*/fwd_data* are 0.
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  regfile_writeback_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] w_count;
  logic [PTR_W-1:0] w_head_ptr;
  wb_entry_t        w_head;
  wb_entry_t        w_entries [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic             w_ready;
  logic             w_push_ld;
  logic             w_push_alu;
  logic             w_pop;
  logic             w_hit1;
  logic             w_hit2;
  logic [DATA_W-1:0] w_fdata1;
  logic [DATA_W-1:0] w_fdata2;

  // Two free slots are always kept so both producers can be accepted together.
  assign w_ready    = (w_count <= CNT_W'(DEPTH - 2));
  assign w_push_ld  = bus.ld_valid  && w_ready && (bus.ld_dest  != REG_ZERO);
  assign w_push_alu = bus.alu_valid && w_ready && (bus.alu_dest != REG_ZERO);
  assign w_pop      = (w_count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push0    (w_push_ld),
    .i_entry0   ('{dest: bus.ld_dest, data: bus.ld_data}),
    .i_push1    (w_push_alu),
    .i_entry1   ('{dest: bus.alu_dest, data: bus.alu_data}),
    .i_pop      (w_pop),
    .o_count    (w_count),
    .o_head_ptr (w_head_ptr),
    .o_head     (w_head),
    .o_entries  (w_entries),
    .o_valid    (w_valid)
  );

  assign bus.alu_ready  = w_ready;
  assign bus.ld_ready   = w_ready;
  assign bus.regwrite   = w_pop;
  assign bus.dest       = w_pop ? w_head.dest : '0;
  assign bus.write_data = w_pop ? w_head.data : '0;

`ifdef REGFILE_WB_FORWARD_EN
  // Walk oldest to youngest so the last match found is the youngest pending value.
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    w_idx    = '0;
    w_hit1   = 1'b0;
    w_hit2   = 1'b0;
    w_fdata1 = '0;
    w_fdata2 = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = w_head_ptr + PTR_W'(k);
      if (w_valid[w_idx] && (bus.fwd_addr1 != REG_ZERO) &&
          (w_entries[w_idx].dest == bus.fwd_addr1)) begin
        w_hit1   = 1'b1;
        w_fdata1 = w_entries[w_idx].data;
      end
      if (w_valid[w_idx] && (bus.fwd_addr2 != REG_ZERO) &&
          (w_entries[w_idx].dest == bus.fwd_addr2)) begin
        w_hit2   = 1'b1;
        w_fdata2 = w_entries[w_idx].data;
      end
    end
  end
`else
  logic w_unused_fwd;

  always_comb begin
    w_unused_fwd = ^{w_head_ptr, w_valid, bus.fwd_addr1, bus.fwd_addr2};
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_unused_fwd = w_unused_fwd ^ (^w_entries[k]);
    end
  end

  assign w_hit1   = 1'b0;
  assign w_hit2   = 1'b0;
  assign w_fdata1 = '0;
  assign w_fdata2 = '0;
`endif

  assign bus.fwd_hit1  = w_hit1;
  assign bus.fwd_hit2  = w_hit2;
  assign bus.fwd_data1 = w_fdata1;
  assign bus.fwd_data2 = w_fdata2;
endmodule
